button_conditioner: RTL and testbench

//  - Parametrised multi-channel push-button conditioner for DE2i-150 KEY/SW inputs.
//  - Per channel: input sync, debounce FSM, one-cycle press/release pulses, optional auto-repeat.
//  - press_pulse drives core single-step and start as a clock enable, so debounced buttons are never used as clocks.

---
 rtl/button_conditioner.sv | 195 +++++++++++++++++++
 tb/tb_button_conditioner.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: synchroniser, debounce FSM, press/release strobes, optional auto-repeat (KEY_AUTOREPEAT_EN).
// Latency: SYNC_STAGES+DEBOUNCE_CYCLES-1 edges from the first sample of a clean edge to the registered level/pulse.
// Backpressure: none; strobes are single-cycle clock enables and are never held or queued.
module button_conditioner #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW_IN   = 1,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] buttons_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic                any_pressed
);

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        CHK_PRESS = 2'd1,
        PRESSED   = 2'd2,
        CHK_REL   = 2'd3
    } state_t;

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw level of an idle button; the sync chain resets here so reset release never looks like a press.
    localparam logic             REL_RAW  = (ACTIVE_LOW_IN != 0);

`ifdef KEY_AUTOREPEAT_EN
    localparam int               RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               RPT_W       = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);
`endif

    if (CHANNELS < 1) begin : g_bad_channels
        $error("button_conditioner: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_conditioner: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_t                 state_q, state_d;
        logic [CNT_W-1:0]       cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   press_q, press_d;
        logic                   rel_q, rel_d;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync_q <= {SYNC_STAGES{REL_RAW}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], buttons_in[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1] ^ REL_RAW;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        // Counter restarts on every reversal and stops at DEBOUNCE_CYCLES-1, so it cannot wrap.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                RELEASED: begin
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                        end else begin
                            state_d = CHK_PRESS;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                CHK_PRESS: begin
                    if (!s) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_d = RELEASED;
                            cnt_d   = '0;
                        end else begin
                            state_d = CHK_REL;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                default: begin
                    if (s) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            endcase
        end

        // A bounce back from CHK_REL to PRESSED is not a new press, hence the source-state qualifiers.
        always_comb begin
            level_d = (state_d == PRESSED) || (state_d == CHK_REL);
            press_d = (state_d == PRESSED) && ((state_q == RELEASED) || (state_q == CHK_PRESS));
            rel_d   = (state_d == RELEASED) && ((state_q == PRESSED) || (state_q == CHK_REL));
        end

        assign level[i]         = level_q;
        assign press_pulse[i]   = press_q;
        assign release_pulse[i] = rel_q;

`ifdef KEY_AUTOREPEAT_EN
        logic [RPT_W-1:0] rcnt_q, rcnt_d;
        logic             in_delay_q, in_delay_d;
        logic             rep_q, rep_d;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                rcnt_q     <= '0;
                in_delay_q <= 1'b1;
                rep_q      <= 1'b0;
            end else begin
                rcnt_q     <= rcnt_d;
                in_delay_q <= in_delay_d;
                rep_q      <= rep_d;
            end
        end

        // Counts only while staying in PRESSED; any entry into PRESSED (or exit from it) rearms the delay.
        always_comb begin
            rcnt_d     = '0;
            in_delay_d = 1'b1;
            rep_d      = 1'b0;
            if (state_q == PRESSED && state_d == PRESSED) begin
                in_delay_d = in_delay_q;
                if (rcnt_q == (in_delay_q ? DELAY_LAST : PERIOD_LAST)) begin
                    rep_d      = 1'b1;
                    in_delay_d = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + RPT_ONE;
                end
            end
        end

        assign repeat_pulse[i] = rep_q;
`else
        assign repeat_pulse[i] = 1'b0;
`endif
    end

    assign any_pressed = |level;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: run-length debounce model compared every cycle, plus literal spot checks.
// Works with or without KEY_AUTOREPEAT_EN defined.
module tb_button_conditioner;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef KEY_AUTOREPEAT_EN
    localparam logic REP_ON = 1'b1;
`else
    localparam logic REP_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] buttons_in = '1;
    logic [CH-1:0] level, press_pulse, release_pulse, repeat_pulse;
    logic          any_pressed;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    button_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_IN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock), .reset(reset), .buttons_in(buttons_in),
        .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .any_pressed(any_pressed)
    );

    // Model: a channel flips once its synchronised input has disagreed with the
    // accepted level for D consecutive edges; repeats are timed by age since the
    // last (re)entry into a steady hold.
    logic [CH-1:0] m_level, m_press, m_rel, m_rep;
    logic [CH-1:0] m_hist [S];
    int            m_run [CH];
    int            m_age [CH];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
            for (int k = 0; k < S; k++) m_hist[k] = '1;
            for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_age[c] = 0; end
        end else begin
            m_press = '0; m_rel = '0; m_rep = '0;
            for (int c = 0; c < CH; c++) begin
                if (~m_hist[S-1][c] == m_level[c]) begin
                    if (m_level[c] && m_run[c] == 0) begin
                        m_age[c] = m_age[c] + 1;
`ifdef KEY_AUTOREPEAT_EN
                        if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0))
                            m_rep[c] = 1'b1;
`endif
                    end else begin
                        m_age[c] = 0;
                    end
                    m_run[c] = 0;
                end else begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == D) begin
                        m_level[c] = ~m_level[c];
                        if (m_level[c]) m_press[c] = 1'b1;
                        else            m_rel[c]   = 1'b1;
                        m_run[c] = 0;
                        m_age[c] = 0;
                    end
                end
            end
            for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = buttons_in;
        end
    end

    always @(posedge clock) begin
        #3;
        checks++;
        if ({level, press_pulse, release_pulse, repeat_pulse, any_pressed} !==
            {m_level, m_press, m_rel, m_rep, |m_level}) begin
            failures++;
            $display("FAIL model_cmp t=%0t: got lvl=%b prs=%b rel=%b rep=%b any=%b expected lvl=%b prs=%b rel=%b rep=%b any=%b",
                     $time, level, press_pulse, release_pulse, repeat_pulse, any_pressed,
                     m_level, m_press, m_rel, m_rep, |m_level);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_state(input string name, input logic [CH-1:0] lvl,
                                input logic [CH-1:0] prs, input logic [CH-1:0] rel);
        checks++;
        if (level !== lvl || press_pulse !== prs || release_pulse !== rel || any_pressed !== (|lvl)) begin
            failures++;
            $display("FAIL %s: got lvl=%b prs=%b rel=%b any=%b expected lvl=%b prs=%b rel=%b any=%b",
                     name, level, press_pulse, release_pulse, any_pressed, lvl, prs, rel, |lvl);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        buttons_in = '1;
        step(3);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            expect_state("idle_after_reset", 4'b0000, 4'b0000, 4'b0000);
            check_bit("idle_repeat", |repeat_pulse, 1'b0);
        end

        // ch0 press: sampled at edge 0, accepted at edge 5
        buttons_in[0] = 1'b0;
        step(5); expect_state("ch0_before_accept", 4'b0000, 4'b0000, 4'b0000);
        step(1); expect_state("ch0_press",         4'b0001, 4'b0001, 4'b0000);
        step(1); expect_state("ch0_held",          4'b0001, 4'b0000, 4'b0000);

        // ch1 three-cycle glitch is rejected, then a held press is accepted
        buttons_in[1] = 1'b0;
        step(3); buttons_in[1] = 1'b1;
        step(8); expect_state("ch1_glitch_ignored", 4'b0001, 4'b0000, 4'b0000);
        buttons_in[1] = 1'b0;
        step(5); expect_state("ch1_before_accept",  4'b0001, 4'b0000, 4'b0000);
        step(1); expect_state("ch1_press",          4'b0011, 4'b0010, 4'b0000);

        // ch0 release and ch3 press on the same edge
        buttons_in[0] = 1'b1;
        buttons_in[3] = 1'b0;
        step(5); expect_state("ch0_ch3_before", 4'b0011, 4'b0000, 4'b0000);
        step(1); expect_state("ch0_rel_ch3_prs", 4'b1010, 4'b1000, 4'b0001);
        step(1); expect_state("ch0_ch3_after",  4'b1010, 4'b0000, 4'b0000);

        // short release bounce on ch3 returns to PRESSED silently
        buttons_in[3] = 1'b1;
        step(2); buttons_in[3] = 1'b0;
        step(8); expect_state("ch3_rel_bounce", 4'b1010, 4'b0000, 4'b0000);

        // ch2 auto-repeat at +10, +13, +16; release entering CHK_REL at +19 kills the +19 repeat
        buttons_in[2] = 1'b0;
        step(5); expect_state("ch2_before_accept", 4'b1010, 4'b0000, 4'b0000);
        step(1); expect_state("ch2_press",         4'b1110, 4'b0100, 4'b0000);
        step(9); check_bit("ch2_rep_p9",  repeat_pulse[2], 1'b0);
        step(1); check_bit("ch2_rep_p10", repeat_pulse[2], REP_ON);
        step(1); check_bit("ch2_rep_p11", repeat_pulse[2], 1'b0);
        step(2); check_bit("ch2_rep_p13", repeat_pulse[2], REP_ON);
        step(3); check_bit("ch2_rep_p16", repeat_pulse[2], REP_ON);
        buttons_in[2] = 1'b1;
        step(3); check_bit("ch2_rep_p19_suppressed", repeat_pulse[2], 1'b0);
                 check_bit("ch2_level_in_chk_rel",   level[2], 1'b1);
        step(3); expect_state("ch2_release", 4'b1010, 4'b0000, 4'b0100);
                 check_bit("ch2_rep_at_release", repeat_pulse[2], 1'b0);

        // reset in CHK_PRESS with cnt=2 discards the count; fresh press after reset release
        buttons_in[0] = 1'b0;
        step(4);
        reset = 1'b0;
        #1;
        expect_state("reset_mid_debounce", 4'b0000, 4'b0000, 4'b0000);
        check_bit("reset_repeat", |repeat_pulse, 1'b0);
        step(2);
        reset = 1'b1;
        step(5); expect_state("post_reset_before", 4'b0000, 4'b0000, 4'b0000);
        step(1); expect_state("post_reset_press",  4'b1011, 4'b1011, 4'b0000);
        step(1); expect_state("post_reset_held",   4'b1011, 4'b0000, 4'b0000);

        // release everything together
        buttons_in = '1;
        step(5); expect_state("all_rel_before", 4'b1011, 4'b0000, 4'b0000);
        step(1); expect_state("all_release",    4'b0000, 4'b0000, 4'b1011);
        step(5); expect_state("all_idle",       4'b0000, 4'b0000, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
